uc_adder2comp: RTL and testbench

UC_ADDER2COMP -- requirements
Module: uc_adder2comp

---
 rtl/uc_adder2comp_pkg.sv | 18 +
 rtl/uc_adder2comp.sv | 124 ++++++++++++
 tb/tb_uc_adder2comp.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uc_adder2comp_pkg.sv
// Shared definitions for the two's-complement adder sequencer and its bench.
package uc_adder2comp_pkg;

  localparam int OPS_W = 8;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD_AB  = 4'd1,
    S_LOAD_MAG = 4'd2,
    S_COMP_MAG = 4'd3,
    S_COMP_SIN = 4'd4,
    S_SOMA_SUB = 4'd5,
    S_LOAD_RES = 4'd6,
    S_CAPTURE  = 4'd7,
    S_DONE     = 4'd8
  } state_e;

endpackage

// File: rtl/uc_adder2comp.sv
// Control unit for the two's-complement adder datapath: latches operands,
// steps the datapath strobes in a fixed order and holds the result until acked.
//
// state      | meaning
// S_IDLE     | ready, waiting for start
// S_LOAD_AB  | datapath loads operands
// S_LOAD_MAG | datapath loads magnitudes
// S_COMP_MAG | datapath compares magnitudes
// S_COMP_SIN | datapath compares signs
// S_SOMA_SUB | datapath adds or subtracts
// S_LOAD_RES | datapath loads its result register
// S_CAPTURE  | res_out takes the datapath result
// S_DONE     | result valid, waiting for out_ack
module uc_adder2comp
  import uc_adder2comp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             start,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic             ready,
  output logic [N-1:0]     a_fd,
  output logic [N-1:0]     b_fd,
  output logic             loadAB,
  output logic             loadmagAB,
  output logic             comp_mag,
  output logic             comp_sinais,
  output logic             soma_sub,
  output logic             loadRES,
  input  logic [N:0]       result,
  output logic [N:0]       res_out,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [OPS_W-1:0] ops_count
);

  state_e           state_q, state_d;
  logic [N-1:0]     a_fd_q, a_fd_d;
  logic [N-1:0]     b_fd_q, b_fd_d;
  logic [N:0]       res_q, res_d;
  logic [OPS_W-1:0] ops_q, ops_d;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= S_IDLE;
      a_fd_q  <= '0;
      b_fd_q  <= '0;
      res_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      a_fd_q  <= a_fd_d;
      b_fd_q  <= b_fd_d;
      res_q   <= res_d;
      ops_q   <= ops_d;
    end
  end

  // Operand and result registers only move on an accepted start or a capture.
  always_comb begin
    state_d = state_q;
    a_fd_d  = a_fd_q;
    b_fd_d  = b_fd_q;
    res_d   = res_q;
    ops_d   = ops_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_fd_d  = a_in;
          b_fd_d  = b_in;
          state_d = S_LOAD_AB;
        end
      end
      S_LOAD_AB:  state_d = S_LOAD_MAG;
      S_LOAD_MAG: state_d = S_COMP_MAG;
      S_COMP_MAG: state_d = S_COMP_SIN;
      S_COMP_SIN: state_d = S_SOMA_SUB;
      S_SOMA_SUB: state_d = S_LOAD_RES;
      S_LOAD_RES: state_d = S_CAPTURE;
      S_CAPTURE: begin
        res_d   = result;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ack) begin
          ops_d   = ops_q + OPS_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    loadAB      = 1'b0;
    loadmagAB   = 1'b0;
    comp_mag    = 1'b0;
    comp_sinais = 1'b0;
    soma_sub    = 1'b0;
    loadRES     = 1'b0;
    out_valid   = 1'b0;
    unique case (state_q)
      S_IDLE:     ready       = 1'b1;
      S_LOAD_AB:  loadAB      = 1'b1;
      S_LOAD_MAG: loadmagAB   = 1'b1;
      S_COMP_MAG: comp_mag    = 1'b1;
      S_COMP_SIN: comp_sinais = 1'b1;
      S_SOMA_SUB: soma_sub    = 1'b1;
      S_LOAD_RES: loadRES     = 1'b1;
      S_DONE:     out_valid   = 1'b1;
      default:    ;
    endcase
  end

  assign a_fd      = a_fd_q;
  assign b_fd      = b_fd_q;
  assign res_out   = res_q;
  assign ops_count = ops_q;

endmodule

// File: tb/tb_uc_adder2comp.sv
// Scoreboard bench for uc_adder2comp with a stub adder datapath.
module tb_uc_adder2comp;
  import uc_adder2comp_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             RESET;
  logic             start;
  logic             out_ack;
  logic [N-1:0]     a_in, b_in;
  logic             ready, out_valid;
  logic [N-1:0]     a_fd, b_fd;
  logic             loadAB, loadmagAB, comp_mag, comp_sinais, soma_sub, loadRES;
  logic [N:0]       result, res_out, stub_sum;
  logic [OPS_W-1:0] ops_count;
  logic [5:0]       strb;
  logic             res_valid_q = 1'b0;

  int               checks = 0;
  int               failures = 0;
  logic [N:0]       sb_q[$];
  logic [OPS_W-1:0] exp_ops = '0;

  uc_adder2comp #(.N(N)) dut (
    .clk(clk), .RESET(RESET), .start(start), .a_in(a_in), .b_in(b_in),
    .ready(ready), .a_fd(a_fd), .b_fd(b_fd),
    .loadAB(loadAB), .loadmagAB(loadmagAB), .comp_mag(comp_mag),
    .comp_sinais(comp_sinais), .soma_sub(soma_sub), .loadRES(loadRES),
    .result(result), .res_out(res_out), .out_valid(out_valid),
    .out_ack(out_ack), .ops_count(ops_count)
  );

  always #5 clk = ~clk;

  // Stub datapath: the sum is only presented the cycle after loadRES, garbage otherwise.
  always @(posedge clk) res_valid_q <= loadRES;
  assign stub_sum = {a_fd[N-1], a_fd} + {b_fd[N-1], b_fd};
  assign result   = res_valid_q ? stub_sum : ~stub_sum;
  assign strb     = {loadAB, loadmagAB, comp_mag, comp_sinais, soma_sub, loadRES};

  function automatic logic [N:0] model_sum(input logic [N-1:0] a, input logic [N-1:0] b);
    return {a[N-1], a} + {b[N-1], b};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    RESET = 1'b1; start = 1'b0; out_ack = 1'b0;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    exp_ops = '0;
    sb_q.delete();
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input int bp, input bit ack_start);
    logic [5:0] exp_s;
    logic [N:0] exp_r;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    sb_q.push_back(model_sum(a, b));
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0; a_in = 4'($urandom); b_in = 4'($urandom);
      exp_s = (k <= 6) ? (6'b100000 >> (k - 1)) : 6'b000000;
      checks++;
      if (strb !== exp_s || ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL strobe_seq cycle %0d: strb=%b ready=%b out_valid=%b, expected strb=%b ready=0 out_valid=0",
                 k, strb, ready, out_valid, exp_s);
      end
      checks++;
      if (a_fd !== a || b_fd !== b) begin
        failures++;
        $display("FAIL operand_hold cycle %0d: a_fd=%b b_fd=%b, expected %b %b", k, a_fd, b_fd, a, b);
      end
    end
    @(negedge clk);
    exp_r = sb_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || ready !== 1'b0 || strb !== 6'b0) begin
      failures++;
      $display("FAIL done_cycle8: out_valid=%b ready=%b strb=%b, expected 1 0 000000", out_valid, ready, strb);
    end
    checks++;
    if (res_out !== exp_r) begin
      failures++;
      $display("FAIL res_out: got %b expected %b", res_out, exp_r);
    end
    checks++;
    if (a_fd !== a || b_fd !== b) begin
      failures++;
      $display("FAIL operand_hold_done: a_fd=%b b_fd=%b, expected %b %b", a_fd, b_fd, a, b);
    end
    for (int i = 0; i < bp; i++) begin
      start = (i % 3 == 0); a_in = 4'($urandom); b_in = 4'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || ready !== 1'b0 || res_out !== exp_r || a_fd !== a ||
          b_fd !== b || ops_count !== exp_ops) begin
        failures++;
        $display("FAIL back_pressure %0d: out_valid=%b ready=%b res_out=%b a_fd=%b b_fd=%b ops=%0d, expected 1 0 %b %b %b %0d",
                 i, out_valid, ready, res_out, a_fd, b_fd, ops_count, exp_r, a, b, exp_ops);
      end
    end
    start = ack_start; a_in = ~a; b_in = ~b; out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0; start = 1'b0;
    exp_ops = exp_ops + 1'b1;
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || ops_count !== exp_ops) begin
      failures++;
      $display("FAIL ack: ready=%b out_valid=%b ops=%0d, expected 1 0 %0d", ready, out_valid, ops_count, exp_ops);
    end
    if (ack_start) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || strb !== 6'b0 || a_fd !== a || b_fd !== b) begin
        failures++;
        $display("FAIL start_with_ack: ready=%b strb=%b a_fd=%b b_fd=%b, expected 1 000000 %b %b",
                 ready, strb, a_fd, b_fd, a, b);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || strb !== 6'b0 || a_fd !== '0 ||
        b_fd !== '0 || res_out !== '0 || ops_count !== '0) begin
      failures++;
      $display("FAIL reset_state: ready=%b out_valid=%b strb=%b a_fd=%b b_fd=%b res_out=%b ops=%0d, expected 1 0 0 0 0 0 0",
               ready, out_valid, strb, a_fd, b_fd, res_out, ops_count);
    end
    a_in = 4'b0101; b_in = 4'b0110; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || strb !== 6'b0 || a_fd !== '0) begin
        failures++;
        $display("FAIL idle_no_start: ready=%b strb=%b a_fd=%b, expected 1 000000 0000", ready, strb, a_fd);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_in = 4'b0101; b_in = 4'b0001; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (soma_sub !== 1'b1) begin
      failures++;
      $display("FAIL reach_soma_sub: soma_sub=%b expected 1", soma_sub);
    end
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    checks++;
    if (ready !== 1'b1 || strb !== 6'b0 || out_valid !== 1'b0 || ops_count !== '0 || a_fd !== '0) begin
      failures++;
      $display("FAIL reset_mid: ready=%b strb=%b out_valid=%b ops=%0d a_fd=%b, expected 1 000000 0 0 0000",
               ready, strb, out_valid, ops_count, a_fd);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || strb !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_idle: ready=%b strb=%b, expected 1 000000", ready, strb);
    end
  endtask

  task automatic test_normal();
    run_op(4'b0011, 4'b0010, 0, 1'b0);
    checks++;
    if (res_out !== 5'b00101 || ops_count !== 8'd1) begin
      failures++;
      $display("FAIL normal_op: res_out=%b ops=%0d, expected 00101 1", res_out, ops_count);
    end
  endtask

  task automatic test_operand_hold();
    run_op(4'b1101, 4'b1110, 0, 1'b0);
    checks++;
    if (res_out !== 5'b11011) begin
      failures++;
      $display("FAIL operand_hold_sum: res_out=%b expected 11011", res_out);
    end
  endtask

  task automatic test_back_pressure();
    run_op(4'b0110, 4'b0111, 10, 1'b0);
  endtask

  task automatic test_start_with_ack();
    run_op(4'b1000, 4'b1111, 2, 1'b1);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_op(4'($urandom), 4'($urandom), 0, 1'b0);
    end
    checks++;
    if (ops_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap: ops_count=%0d expected 0", ops_count);
    end
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; out_ack = 1'b0; a_in = '0; b_in = '0;
    do_reset();
    test_reset();
    test_reset_mid();
    test_normal();
    test_operand_hold();
    test_back_pressure();
    test_start_with_ack();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
